// File: rtl/sub32_seq_if.sv
// Valid/ready operand and result bundle for the slice-serial subtractor.
interface sub32_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, ovf
    );
endinterface

// File: rtl/sub32_seq.sv
// Multi-cycle subtractor: diff = a + ~b + 1 using one SLICE-bit adder reused
// over WIDTH/SLICE cycles, low slice first, carry registered between slices.
//
//   state | meaning
//   IDLE  | ready for operands, no result presented
//   RUN   | one slice added per cycle, idx selects the slice
//   DONE  | result held on diff/borrow/ovf until out_ready
module sub32_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 16
) (
    input  logic        clk,
    input  logic        areset_n,
    sub32_seq_if.slave  bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    generate
        if (WIDTH % SLICE != 0) begin : g_bad_width
            $error("sub32_seq: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic              accept, in_ready_c, out_valid_c;
    logic              last_slice;
    logic [WIDTH-1:0]  a_r, nb_r, diff_r;
    logic              carry_r, borrow_r, ovf_r;
    logic [IDXW-1:0]   idx;
    logic [SLICE-1:0]  a_sl, nb_sl, s_sl;
    logic              c_out;

    always_comb begin
        a_sl          = a_r[int'(idx)*SLICE +: SLICE];
        nb_sl         = nb_r[int'(idx)*SLICE +: SLICE];
        {c_out, s_sl} = {1'b0, a_sl} + {1'b0, nb_sl} + (SLICE+1)'(carry_r);
        last_slice    = (idx == LAST_IDX);
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_slice) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            a_r      <= '0;
            nb_r     <= '0;
            diff_r   <= '0;
            carry_r  <= 1'b0;
            borrow_r <= 1'b0;
            ovf_r    <= 1'b0;
            idx      <= '0;
        end else if (accept) begin
            a_r     <= bus.a;
            nb_r    <= ~bus.b;
            carry_r <= 1'b1;
            idx     <= '0;
        end else if (state == RUN) begin
            diff_r[int'(idx)*SLICE +: SLICE] <= s_sl;
            carry_r <= c_out;
            idx     <= last_slice ? '0 : idx + 1'b1;
            if (last_slice) begin
                borrow_r <= ~c_out;
                // a and b differ in sign exactly when a and ~b share an MSB
                ovf_r    <= (a_r[WIDTH-1] == nb_r[WIDTH-1]) && (s_sl[SLICE-1] != a_r[WIDTH-1]);
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.diff      = diff_r;
    assign bus.borrow    = borrow_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_sub32_seq.sv
// Directed and randomized checks of sub32_seq against an arithmetic reference.
module tb_sub32_seq;
    localparam int WIDTH  = 32;
    localparam int SLICE  = 16;
    localparam int NSLICE = WIDTH / SLICE;
    localparam int NOPS   = 1000;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
    } op_t;

    logic clk = 1'b0;
    logic areset_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    sub32_seq_if #(.WIDTH(WIDTH)) bus ();

    sub32_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk      (clk),
        .areset_n (areset_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // {borrow, ovf, diff}
    function automatic logic [33:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        logic        br;
        logic        ov;
        longint      sd;
        d  = a - b;
        br = (a < b);
        sd = longint'($signed(a)) - longint'($signed(b));
        ov = (sd > SMAX) || (sd < SMIN);
        return {br, ov, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corner [5];
        corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    task automatic directed(input logic [31:0] a, input logic [31:0] b, input int hold, input bit noisy);
        logic [33:0] r;
        logic [31:0] held;
        int          n;
        r = ref_sub(a, b);
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 1);
        check("idle_out_valid", bus.out_valid, 0);
        bus.a         = a;
        bus.b         = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(negedge clk);
        bus.in_valid = noisy;
        bus.a        = $urandom;
        bus.b        = $urandom;
        check("run_in_ready", bus.in_ready, 0);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, NSLICE);
        check("diff", bus.diff, r[31:0]);
        check("borrow", bus.borrow, r[33]);
        check("ovf", bus.ovf, r[32]);
        held = bus.diff;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.a = $urandom;
            check("hold_valid", bus.out_valid, 1);
            check("hold_diff", bus.diff, held);
            check("hold_in_ready", bus.in_ready, 0);
        end
        if (hold > 0) begin
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b0;
            @(negedge clk);
            check("release_valid", bus.out_valid, 0);
            check("release_diff_kept", bus.diff, r[31:0]);
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        op_t         q[$];
        op_t         op;
        logic [33:0] r;
        int          cyc;
        int          issued;
        int          done;
        int          last_valid;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_diff", bus.diff, 0);
        check("rst_borrow", bus.borrow, 0);
        check("rst_ovf", bus.ovf, 0);
        areset_n = 1'b1;

        directed(32'h0001_0000, 32'h1, 0, 1'b0);
        directed(32'h0, 32'h1, 0, 1'b0);
        directed(32'h1234_5678, 32'h1234_5678, 0, 1'b0);
        directed(32'h8000_0000, 32'h1, 0, 1'b0);
        directed(32'hCAFE_0123, 32'h0BAD_F00D, 5, 1'b1);
        directed(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);

        // reset asserted while the operation is in RUN
        @(negedge clk);
        bus.a         = 32'hDEAD_BEEF;
        bus.b         = 32'h1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        areset_n     = 1'b0;
        #1;
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_diff", bus.diff, 0);
        check("midrst_borrow", bus.borrow, 0);
        check("midrst_ovf", bus.ovf, 0);
        @(negedge clk);
        areset_n = 1'b1;
        directed(32'd5, 32'd3, 0, 1'b0);

        // back-to-back with in_valid and out_ready tied high
        cyc        = 0;
        issued     = 0;
        done       = 0;
        last_valid = -1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        while (done < NOPS && cyc < 6 * NOPS) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid === 1'b1) begin
                check("bb_pending", 32'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    op = q.pop_front();
                    r  = ref_sub(op.a, op.b);
                    check("bb_diff", bus.diff, r[31:0]);
                    check("bb_borrow", bus.borrow, r[33]);
                    check("bb_ovf", bus.ovf, r[32]);
                    check("bb_latency", cyc - op.cyc, NSLICE + 1);
                    if (last_valid >= 0) check("bb_period", cyc - last_valid, NSLICE + 2);
                end
                last_valid = cyc;
                done++;
            end
            if (issued >= NOPS) begin
                bus.in_valid = 1'b0;
            end else if (bus.in_ready === 1'b1) begin
                bus.a = pick_operand();
                bus.b = pick_operand();
                q.push_back('{a: bus.a, b: bus.b, cyc: cyc});
                issued++;
            end
        end
        check("bb_count", done, NOPS);
        check("bb_queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
